branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequencing controller wrapped around the ID-stage branch resolution unit. It qualifies each resolved branch/jump, stalls ID while operands are not ready, and registers a taken redirect. The redirect is held toward the fetch stage until fetch accepts it. It also tracks the MIPS delay-slot flag for the following instruction and keeps saturating branch statistics counters.

Parameters:
CNT_W, 16, width of statistics counters
RESET_PC, 32'hBFC00000, reset value of redirect_pc

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a valid instruction this cycle
id_is_branch  in  1  ID instruction is a branch/jump (J, JAL, JR, JALR, Bxx, BxxAL)
branch_flag  in  1  resolved taken flag from branch unit
branch_target_addr  in  32  resolved target from branch unit
operand_hazard  in  1  reg1/reg2 of ID instruction depend on an in-flight load
ex_stall  in  1  downstream stall; ID must hold
flush  in  1  exception/eret flush of the pipeline front end
if_ready  in  1  fetch accepts a redirect this cycle
stall_req  out  1  request ID/IF hold (combinational)
redirect_valid  out  1  redirect pending toward fetch
redirect_pc  out  32  redirect target
id_in_delay_slot  out  1  current ID instruction is a delay slot
branch_cnt  out  CNT_W  accepted branches
taken_cnt  out  CNT_W  accepted taken branches

Behaviour:
- Reset: state=IDLE, redirect_valid=0, redirect_pc=RESET_PC, id_in_delay_slot=0, both counters=0. Reset mid-PEND drops the redirect.
- stall_req = !flush && id_valid && id_is_branch && (operand_hazard || state==PEND). Combinational.
- accept = id_valid && !ex_stall && !stall_req && !flush. br_accept = accept && id_is_branch.
- FSM states: IDLE, PEND.
- IDLE:
  - br_accept && branch_flag: redirect_pc <= branch_target_addr; state <= PEND.
  - br_accept && !branch_flag: stay in IDLE.
- PEND:
  - redirect_valid = (state==PEND) && !flush.
  - Handshake completes when redirect_valid && if_ready; state <= IDLE on the next edge.
  - redirect_pc is stable throughout PEND.
  - A second branch in ID during PEND is held by stall_req, including in the handshake cycle. It is evaluated in IDLE on the following cycle.
- Latency: a taken branch accepted in cycle N gives redirect_valid=1 in cycle N+1 at the earliest. Minimum redirect lifetime is 1 cycle.
- Delay slot:
  - On br_accept, id_in_delay_slot <= 1 (taken or not).
  - On a non-branch accept, id_in_delay_slot <= 0.
  - If neither occurs, id_in_delay_slot holds its value, including across ex_stall.
- Flush has highest priority after rst:
  - Next state is IDLE and id_in_delay_slot <= 0.
  - No latch and no counter update in the flush cycle.
  - redirect_valid is forced 0 in the flush cycle, so no handshake can occur.
- Counters:
  - branch_cnt += 1 on br_accept.
  - taken_cnt += 1 on br_accept && branch_flag.
  - Both saturate at all-ones with no wrap.
- id_is_branch, branch_flag and branch_target_addr are ignored when id_valid=0.
- ex_stall=1 blocks accept but does not raise stall_req. A PEND redirect may still complete during ex_stall.

Test Plan:
- Not-taken BEQ: id_valid=1, id_is_branch=1, branch_flag=0 -> redirect_valid stays 0; branch_cnt=1, taken_cnt=0; id_in_delay_slot=1 next cycle; cleared after the next non-branch accept.
- Taken J to 0x80001000 with if_ready=0 for 3 cycles then 1 -> redirect_valid=1 from cycle N+1 through the if_ready cycle; redirect_pc=0x80001000 constant; IDLE afterward; taken_cnt=1.
- operand_hazard=1 for 2 cycles on BNE (taken, target 0x80000040) -> stall_req=1 for those 2 cycles with no counter change; accepted on cycle 3; redirect 0x80000040 on cycle 4.
- Flush in the cycle a taken branch is presented, then flush during PEND with if_ready=1 -> first case: nothing latched and counters unchanged. Second case: redirect_valid=0 that cycle, state IDLE next, id_in_delay_slot=0.
- Branch in ID while PEND -> stall_req=1 until the handshake cycle completes; that branch is accepted in the following cycle.
- Counter saturation with CNT_W=4: 17 taken branches -> branch_cnt=taken_cnt=4'hF; synchronous rst -> all outputs return to reset values, redirect_pc=0xBFC00000.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Signal bundle between the ID-stage pipeline, the branch unit and the
// redirect controller. The controller sits on the slave side.
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_is_branch;
  logic             branch_flag;
  logic [31:0]      branch_target_addr;
  logic             operand_hazard;
  logic             ex_stall;
  logic             flush;
  logic             if_ready;
  logic             stall_req;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             id_in_delay_slot;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_valid, id_is_branch, branch_flag, branch_target_addr,
           operand_hazard, ex_stall, flush, if_ready,
    input  stall_req, redirect_valid, redirect_pc, id_in_delay_slot,
           branch_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_is_branch, branch_flag, branch_target_addr,
           operand_hazard, ex_stall, flush, if_ready,
    output stall_req, redirect_valid, redirect_pc, id_in_delay_slot,
           branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch sequencing: qualifies resolved branches, stalls on operand
// hazards or an outstanding redirect, holds the redirect until fetch takes it.
module branch_redirect_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      redirect_pc_q;
  logic             delay_slot_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic pend;
  logic accept;
  logic br_accept;
  logic br_taken;
  logic redirect_valid;
  logic handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign pend = (state == PEND);

  // A branch may not resolve while a previous redirect is still unclaimed,
  // so the second branch waits in ID until the FSM is back in IDLE.
  assign bus.stall_req = !bus.flush && bus.id_valid && bus.id_is_branch &&
                         (bus.operand_hazard || pend);

  assign accept    = bus.id_valid && !bus.ex_stall && !bus.stall_req && !bus.flush;
  assign br_accept = accept && bus.id_is_branch;
  assign br_taken  = br_accept && bus.branch_flag;

  assign redirect_valid = pend && !bus.flush;
  assign handshake      = redirect_valid && bus.if_ready;

  // Flush outranks everything but reset: it kills a pending redirect and the
  // delay-slot tag, and no branch is counted or latched in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      redirect_pc_q <= RESET_PC;
      delay_slot_q  <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else if (bus.flush) begin
      state        <= IDLE;
      delay_slot_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_taken) begin
            redirect_pc_q <= bus.branch_target_addr;
            state         <= PEND;
          end
        end
        PEND: begin
          if (handshake) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (br_accept)   delay_slot_q <= 1'b1;
      else if (accept) delay_slot_q <= 1'b0;

      if (br_accept) branch_cnt_q <= sat_inc(branch_cnt_q);
      if (br_taken)  taken_cnt_q  <= sat_inc(taken_cnt_q);
    end
  end

  assign bus.redirect_valid   = redirect_valid;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.id_in_delay_slot = delay_slot_q;
  assign bus.branch_cnt       = branch_cnt_q;
  assign bus.taken_cnt        = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: scenario tasks with inline checks plus a
// scoreboard of expected redirect targets consumed at each fetch handshake.
module tb_branch_redirect_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(
    .CNT_W   (CNT_W),
    .RESET_PC(32'hBFC00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard consumer: every completed handshake must match the oldest
  // expected target.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    #2;
    if (mon_en && !rst && bus.redirect_valid && bus.if_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_handshake: got redirect pc=%h, expected no redirect", bus.redirect_pc);
      end else begin
        exp_pc = sb.pop_front();
        if (bus.redirect_pc !== exp_pc) begin
          bad++;
          $display("FAIL sb_redirect_pc: got %h, expected %h", bus.redirect_pc, exp_pc);
        end
      end
    end
  end

  task automatic drv(input logic v, input logic b, input logic f, input logic [31:0] t,
                     input logic hz, input logic es, input logic fl, input logic rdy);
    bus.id_valid           = v;
    bus.id_is_branch       = b;
    bus.branch_flag        = f;
    bus.branch_target_addr = t;
    bus.operand_hazard     = hz;
    bus.ex_stall           = es;
    bus.flush              = fl;
    bus.if_ready           = rdy;
  endtask

  task automatic idle(input logic rdy);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_rv: got %b, expected 0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'hBFC00000) begin bad++; $display("FAIL rst_pc: got %h, expected bfc00000", bus.redirect_pc); end
    total++; if (bus.id_in_delay_slot !== 1'b0) begin bad++; $display("FAIL rst_ds: got %b, expected 0", bus.id_in_delay_slot); end
    total++; if (bus.branch_cnt !== 4'h0 || bus.taken_cnt !== 4'h0) begin bad++; $display("FAIL rst_cnt: got %h/%h, expected 0/0", bus.branch_cnt, bus.taken_cnt); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b, expected 0", bus.stall_req); end
    @(negedge clk);
  endtask

  task automatic test_not_taken();
    do_reset();
    drv(1'b1, 1'b1, 1'b0, 32'h80000800, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL nt_stall: got %b, expected 0", bus.stall_req); end
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL nt_rv: got %b, expected 0", bus.redirect_valid); end
    total++; if (bus.branch_cnt !== 4'h1 || bus.taken_cnt !== 4'h0) begin bad++; $display("FAIL nt_cnt: got %h/%h, expected 1/0", bus.branch_cnt, bus.taken_cnt); end
    total++; if (bus.id_in_delay_slot !== 1'b1) begin bad++; $display("FAIL nt_ds_set: got %b, expected 1", bus.id_in_delay_slot); end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.id_in_delay_slot !== 1'b0) begin bad++; $display("FAIL nt_ds_clr: got %b, expected 0", bus.id_in_delay_slot); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL nt_rv2: got %b, expected 0", bus.redirect_valid); end
    @(negedge clk);
  endtask

  task automatic test_taken_jump();
    do_reset();
    drv(1'b1, 1'b1, 1'b1, 32'h80001000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80001000);
    #2;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL j_rv_n: got %b, expected 0", bus.redirect_valid); end
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (bus.taken_cnt !== 4'h1) begin bad++; $display("FAIL j_taken_cnt: got %h, expected 1", bus.taken_cnt); end
    total++; if (bus.id_in_delay_slot !== 1'b1) begin bad++; $display("FAIL j_ds: got %b, expected 1", bus.id_in_delay_slot); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        idle(i == 3);
        #2;
      end
      total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL j_rv_hold%0d: got %b, expected 1", i, bus.redirect_valid); end
      total++; if (bus.redirect_pc !== 32'h80001000) begin bad++; $display("FAIL j_pc_hold%0d: got %h, expected 80001000", i, bus.redirect_pc); end
    end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL j_rv_after: got %b, expected 0", bus.redirect_valid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL j_sb_left: got %0d entries, expected 0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 1'b1, 1'b1, 32'h80000040, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL hz_stall%0d: got %b, expected 1", i, bus.stall_req); end
      total++; if (bus.branch_cnt !== 4'h0) begin bad++; $display("FAIL hz_cnt%0d: got %h, expected 0", i, bus.branch_cnt); end
      @(negedge clk);
    end
    drv(1'b1, 1'b1, 1'b1, 32'h80000040, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80000040);
    #2;
    total++; if (bus.stall_req !== 1'b0 || bus.branch_cnt !== 4'h0) begin bad++; $display("FAIL hz_accept: got stall=%b cnt=%h, expected 0/0", bus.stall_req, bus.branch_cnt); end
    @(negedge clk);
    idle(1'b1);
    #2;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80000040) begin bad++; $display("FAIL hz_redirect: got rv=%b pc=%h, expected 1/80000040", bus.redirect_valid, bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 4'h1) begin bad++; $display("FAIL hz_cnt_after: got %h, expected 1", bus.branch_cnt); end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL hz_done: got rv=%b sb=%0d, expected 0/0", bus.redirect_valid, sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    do_reset();
    drv(1'b1, 1'b1, 1'b1, 32'h80002000, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL fl_stall: got %b, expected 0", bus.stall_req); end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'hBFC00000) begin bad++; $display("FAIL fl_nolatch: got rv=%b pc=%h, expected 0/bfc00000", bus.redirect_valid, bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 4'h0 || bus.taken_cnt !== 4'h0 || bus.id_in_delay_slot !== 1'b0) begin bad++; $display("FAIL fl_nocount: got %h/%h ds=%b, expected 0/0 ds=0", bus.branch_cnt, bus.taken_cnt, bus.id_in_delay_slot); end
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80003000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80003000);
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b1 || bus.id_in_delay_slot !== 1'b1) begin bad++; $display("FAIL fl_pend: got rv=%b ds=%b, expected 1/1", bus.redirect_valid, bus.id_in_delay_slot); end
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    void'(sb.pop_front());
    #2;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL fl_rv_forced: got %b, expected 0", bus.redirect_valid); end
    @(negedge clk);
    idle(1'b1);
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || bus.id_in_delay_slot !== 1'b0) begin bad++; $display("FAIL fl_after: got rv=%b ds=%b, expected 0/0", bus.redirect_valid, bus.id_in_delay_slot); end
    total++; if (bus.branch_cnt !== 4'h1 || bus.taken_cnt !== 4'h1) begin bad++; $display("FAIL fl_cnt: got %h/%h, expected 1/1", bus.branch_cnt, bus.taken_cnt); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drv(1'b1, 1'b1, 1'b1, 32'h80004000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80004000);
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80005000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (bus.stall_req !== 1'b1 || bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold: got stall=%b rv=%b, expected 1/1", bus.stall_req, bus.redirect_valid); end
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80005000, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL b2b_hs_stall: got %b, expected 1", bus.stall_req); end
    total++; if (bus.branch_cnt !== 4'h1) begin bad++; $display("FAIL b2b_cnt1: got %h, expected 1", bus.branch_cnt); end
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80005000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80005000);
    #2;
    total++; if (bus.stall_req !== 1'b0 || bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL b2b_release: got stall=%b rv=%b, expected 0/0", bus.stall_req, bus.redirect_valid); end
    @(negedge clk);
    idle(1'b1);
    #2;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80005000) begin bad++; $display("FAIL b2b_second: got rv=%b pc=%h, expected 1/80005000", bus.redirect_valid, bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 4'h2 || bus.taken_cnt !== 4'h2) begin bad++; $display("FAIL b2b_cnt2: got %h/%h, expected 2/2", bus.branch_cnt, bus.taken_cnt); end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL b2b_done: got rv=%b sb=%0d, expected 0/0", bus.redirect_valid, sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_ex_stall();
    do_reset();
    drv(1'b1, 1'b1, 1'b1, 32'h80006000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL es_stall: got %b, expected 0", bus.stall_req); end
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80006000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h80006000);
    #2;
    total++; if (bus.branch_cnt !== 4'h0 || bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL es_blocked: got cnt=%h rv=%b, expected 0/0", bus.branch_cnt, bus.redirect_valid); end
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL es_pend_rv: got %b, expected 1", bus.redirect_valid); end
    @(negedge clk);
    drv(1'b0, 1'b1, 1'b1, 32'h80007000, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || bus.id_in_delay_slot !== 1'b1) begin bad++; $display("FAIL es_after: got rv=%b ds=%b, expected 0/1", bus.redirect_valid, bus.id_in_delay_slot); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL es_novalid_stall: got %b, expected 0", bus.stall_req); end
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.branch_cnt !== 4'h1 || bus.redirect_valid !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL es_ignore: got cnt=%h rv=%b sb=%0d, expected 1/0/0", bus.branch_cnt, bus.redirect_valid, sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tgt = 32'h80010000 + 32'(i * 16);
      drv(1'b1, 1'b1, 1'b1, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
      sb.push_back(tgt);
      @(negedge clk);
      idle(1'b1);
      @(negedge clk);
    end
    idle(1'b0);
    #2;
    total++; if (bus.branch_cnt !== 4'hF || bus.taken_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt: got %h/%h, expected f/f", bus.branch_cnt, bus.taken_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sat_sb_left: got %0d entries, expected 0", sb.size()); end
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 32'h80020000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    #2;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80020000) begin bad++; $display("FAIL sat_pend: got rv=%b pc=%h, expected 1/80020000", bus.redirect_valid, bus.redirect_pc); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    total++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'hBFC00000) begin bad++; $display("FAIL sat_rst_rv: got rv=%b pc=%h, expected 0/bfc00000", bus.redirect_valid, bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 4'h0 || bus.taken_cnt !== 4'h0 || bus.id_in_delay_slot !== 1'b0) begin bad++; $display("FAIL sat_rst_cnt: got %h/%h ds=%b, expected 0/0 ds=0", bus.branch_cnt, bus.taken_cnt, bus.id_in_delay_slot); end
    @(negedge clk);
  endtask

  initial begin
    idle(1'b0);
    mon_en = 1'b1;
    test_reset();
    test_not_taken();
    test_taken_jump();
    test_hazard();
    test_flush();
    test_back_to_back();
    test_ex_stall();
    test_saturation();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
